// File: rtl/key_pkg.sv
// Shared definitions for the key event path: arbiter state encoding,
// default timing constants and the event-index width helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } arb_state_e;

  localparam int CLK_HZ    = 50_000_000;
  localparam int GAP_1MS   = 50_000;
  localparam int REP_500MS = 25_000_000;

  // Width of an index into n keys; never narrower than one bit.
  function automatic int id_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// ptr, wrapping modulo KEY_W. Also used by the LED/menu schedulers.
module rr_pick
  import key_pkg::*;
#(
  parameter int KEY_W = 4,
  parameter int ID_W  = id_w_f(KEY_W)
) (
  input  logic [KEY_W-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx,
  output logic [KEY_W-1:0] onehot
);

  always_comb begin
    int pos;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned and no latch is inferred.
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = 0;
    for (int k = 1; k <= KEY_W; k++) begin
      pos = (int'(ptr) + k) % KEY_W;
      if (!any && req[pos]) begin
        any         = 1'b1;
        idx         = ID_W'(pos);
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_evt_arbiter.sv
// Holds debounced key presses as pending requests and delivers them one at a
// time, round-robin, over valid/ready. KEY_EVT_REPEAT_EN adds hold-to-repeat.
module key_evt_arbiter
  import key_pkg::*;
#(
  parameter int KEY_W   = 4,
  parameter int GAP_CYC = GAP_1MS,
`ifdef KEY_EVT_REPEAT_EN
  parameter int REP_CYC = REP_500MS,
`endif
  parameter int ID_W    = id_w_f(KEY_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_vld,
`ifdef KEY_EVT_REPEAT_EN
  input  logic [KEY_W-1:0] key_hold,
`endif
  output logic             evt_vld,
  input  logic             evt_rdy,
  output logic [ID_W-1:0]  evt_id,
  output logic [KEY_W-1:0] evt_onehot,
  output logic             busy,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  arb_state_e       state_q, state_d;
  logic [KEY_W-1:0] pend_q, pend_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [KEY_W-1:0] onehot_q, onehot_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             ovf_q, ovf_d;

  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic [KEY_W-1:0] pick_onehot;
  logic             hs;
  logic [KEY_W-1:0] clr_mask;
  logic [KEY_W-1:0] rep_set;

  rr_pick #(.KEY_W(KEY_W), .ID_W(ID_W)) u_pick (
    .req    (pend_q),
    .ptr    (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign hs       = (state_q == PRESENT) && evt_rdy;
  assign clr_mask = hs ? onehot_q : '0;

`ifdef KEY_EVT_REPEAT_EN
  localparam int REP_W = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;

  logic [KEY_W-1:0] hold_q;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_arm, rep_fire;

  // Repeats run only while a single key is held with no change since last cycle.
  assign rep_arm  = (key_hold == hold_q) && (key_hold != '0) &&
                    ((key_hold & (key_hold - KEY_W'(1))) == '0);
  assign rep_fire = rep_arm && (rep_cnt_q == REP_W'(REP_CYC - 1));
  assign rep_set  = rep_fire ? key_hold : '0;

  always_comb begin
    rep_cnt_d = '0;
    if (rep_arm && !rep_fire) rep_cnt_d = rep_cnt_q + REP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      rep_cnt_q <= '0;
    end else begin
      hold_q    <= key_hold;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign rep_set = '0;
`endif

  // New presses win over a same-cycle clear; only real presses can overflow.
  assign pend_d = (pend_q & ~clr_mask) | key_vld | rep_set;
  assign ovf_d  = (ovf_q & ~clr_ovf) | (|(key_vld & pend_q & ~clr_mask));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    onehot_d  = onehot_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          id_d     = pick_idx;
          onehot_d = pick_onehot;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (hs) begin
          rr_ptr_d  = id_q;
          gap_cnt_d = '0;
          state_d   = (GAP_CYC > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      rr_ptr_q  <= ID_W'(KEY_W - 1);
      id_q      <= '0;
      onehot_q  <= '0;
      gap_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      onehot_q  <= onehot_d;
      gap_cnt_q <= gap_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign evt_vld    = (state_q == PRESENT);
  assign evt_id     = id_q;
  assign evt_onehot = evt_vld ? onehot_q : '0;
  assign busy       = (pend_q != '0) || (state_q != IDLE);
  assign ovf        = ovf_q;

endmodule

// File: doc/key_evt_arbiter.md
Name: key_evt_arbiter

Overview:
- Collects one-cycle debounced key pulses from the key debounce stage (KEY_W keys) and holds each as a pending request.
- Round-robin arbitrates pending keys and delivers one event at a time to a consumer (menu/control FSM) over a valid/ready handshake.
- Optionally enforces a minimum gap between delivered events.
- Sits between the debouncer and every key-driven consumer, so simultaneous presses are never lost or merged.

Parameters:
- KEY_W, 4: number of keys; must be ≥ 2.
- GAP_CYC, 50000: idle cycles enforced after each accepted event (1 ms @ 50 MHz); 0 disables the gap.
- ID_W, $clog2(KEY_W): width of the event index.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: reset.
- key_vld, input, KEY_W: one-cycle debounced press pulses; multiple bits may be high in the same cycle.
- evt_vld, output, 1: event available.
- evt_rdy, input, 1: consumer accepts the event.
- evt_id, output, ID_W: index of the key being presented.
- evt_onehot, output, KEY_W: one-hot form of evt_id; all-zero when evt_vld = 0.
- busy, output, 1: any request pending, or FSM not in IDLE.
- ovf, output, 1: sticky flag; a press was dropped.
- clr_ovf, input, 1: clears ovf.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pend = 0, state = IDLE, rr_ptr = KEY_W-1, gap_cnt = 0.
  - evt_vld = 0, evt_id = 0, evt_onehot = 0, busy = 0, ovf = 0.
  - Reset asserted mid-handshake or mid-gap discards all pending events; no event is emitted afterwards.
- Pending register pend[KEY_W]:
  - key_vld[i] = 1 sets pend[i] on the next edge.
  - pend[i] clears on handshake (evt_vld & evt_rdy) with evt_id = i.
  - Same-cycle handshake clear and new key_vld[i]: set wins; the new press becomes a new event.
  - key_vld[i] while pend[i] = 1 and not being cleared: press dropped, ovf <= 1.
- ovf:
  - clr_ovf clears ovf.
  - Same-cycle clr_ovf and new drop: ovf stays 1.
- FSM states IDLE, PRESENT, GAP:
  - IDLE: if pend != 0, pick the winner = first set bit searching from rr_ptr+1 upward, wrapping modulo KEY_W. Load evt_id/evt_onehot, go to PRESENT.
  - PRESENT: evt_vld = 1. evt_id and evt_onehot are held stable until handshake.
    - On handshake: clear pend[evt_id], set rr_ptr <= evt_id, drop evt_vld next cycle.
    - Next state is GAP if GAP_CYC > 0, else IDLE.
  - GAP: gap_cnt counts 0..GAP_CYC-1; at GAP_CYC-1 go to IDLE. Requests keep accumulating during GAP.
- Latency:
  - key_vld[i] high in cycle 0 → pend[i] high in cycle 1 → evt_vld high in cycle 2, provided FSM is IDLE and no higher-priority request is pending.
  - evt_rdy held high with GAP_CYC = 0: one event every 2 cycles (PRESENT then IDLE).
- Fairness:
  - A continuously pending key waits at most KEY_W-1 other events.
  - rr_ptr changes only on handshake.
- evt_rdy when evt_vld = 0 is ignored.
- busy = (pend != 0) | (state != IDLE), registered-state based.

Optional Feature:
- Macro KEY_EVT_REPEAT_EN.
- Defined:
  - Input key_hold[KEY_W] (level, debounced) is added, plus parameter REP_CYC (default 25000000 = 0.5 s).
  - While exactly one key_hold bit is high continuously, a per-block repeat counter re-sets the corresponding pend bit every REP_CYC cycles, counted from its press.
  - Counter resets when key_hold changes or goes to 0.
  - Repeats that hit an already-pending bit are dropped silently; they do not set ovf.
- Not defined: no key_hold port, no repeat logic; behaviour exactly as above.

Decomposition:
- Shared package key_pkg:
  - state enum (IDLE, PRESENT, GAP).
  - Default constants: CLK_HZ = 50000000, GAP_1MS = 50000, REP_500MS = 25000000.
  - Function for the ID_W calculation.
- Sub-module rr_pick (combinational round-robin priority picker):
  - Inputs: req[KEY_W], ptr[ID_W].
  - Outputs: any, idx, onehot.
  - Reused by the planned LED/menu schedulers.
- FSM, pend and counters stay in key_evt_arbiter.

Test Plan:
- Single press, KEY_W = 4, GAP_CYC = 0, evt_rdy = 1: key_vld = 4'b0100 at cycle 0 → evt_vld = 1 with evt_id = 2 at cycle 2, evt_vld = 0 at cycle 3, busy = 0 at cycle 4.
- Simultaneous presses after reset: key_vld = 4'b1011, evt_rdy = 1 → events emitted in order 0, 1, 3, each separated by one IDLE cycle, ovf = 0.
- Backpressure: evt_rdy = 0 for 10 cycles after press of key 1 → evt_vld and evt_id = 1 stable for all 10 cycles. Second pulse on key 1 during the wait → ovf = 1. Clear-and-set case: pulse on key 1 in the handshake cycle → second event for key 1 follows.
- Fairness: pend held for keys 0 and 3 by re-pulsing each after its accept → grants alternate 0, 3, 0, 3; never two consecutive grants of the same key.
- Gap, GAP_CYC = 8: two presses in the same cycle → second evt_vld rises exactly 8 cycles after the first handshake edge plus 1 IDLE cycle. Reset asserted at gap cycle 4 → busy = 0 and no further event.
- KEY_EVT_REPEAT_EN with REP_CYC = 100: key_hold[2] high for 350 cycles, evt_rdy = 1 → 1 press event + 3 repeat events with evt_id = 2. Hold on two keys → no repeats.
